// File: rtl/cpx_io_req_credit_buf.sv
// Registered IO-side CPX request/grant buffer with per-destination outstanding-packet
// credit tracking: one flop stage for req/grant, registered stall/busy, sticky errors.
module cpx_io_req_credit_buf #(
  parameter int NDEST          = 8,
  parameter int DEPTH          = 2,
  parameter int CNTW           = 2,
  parameter bit REQ_ACTIVE_LOW = 1'b1
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic [NDEST-1:0] io_cpx_req_cq,
  input  logic [NDEST-1:0] cpx_io_grant_ca,
  input  logic             io_cpx_err_clr,
  output logic [NDEST-1:0] io_cpx_req_bufio_cq_l,
  output logic [NDEST-1:0] cpx_io_grant_bufio_ca,
  output logic [NDEST-1:0] io_cpx_stall_cq,
  output logic             io_cpx_busy,
  output logic             io_cpx_ovfl_err,
  output logic             io_cpx_undfl_err
);

  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  logic [CNTW-1:0]  cnt_q [NDEST];
  logic [CNTW-1:0]  cnt_d [NDEST];
  logic [NDEST-1:0] req_q, req_d;
  logic [NDEST-1:0] grant_q, grant_d;
  logic             ovfl_q, ovfl_d;
  logic             undfl_q, undfl_d;

  logic [NDEST-1:0] full;
  logic [NDEST-1:0] empty;
  logic [NDEST-1:0] acc;
  logic [NDEST-1:0] ret;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int d = 0; d < NDEST; d++) begin
      full[d]  = (cnt_q[d] == DEPTH_C);
      empty[d] = (cnt_q[d] == '0);
    end
  end

  // A request at full is dropped even when a grant frees a slot in the same cycle.
  assign acc = io_cpx_req_cq & ~full;
  assign ret = cpx_io_grant_ca & ~empty;

  always_comb begin
    for (int d = 0; d < NDEST; d++) begin
      cnt_d[d] = cnt_q[d];
      if (acc[d] && !ret[d]) begin
        cnt_d[d] = cnt_q[d] + ONE_C;
      end else if (ret[d] && !acc[d]) begin
        cnt_d[d] = cnt_q[d] - ONE_C;
      end
    end
  end

  always_comb begin
    req_d   = acc;
    grant_d = cpx_io_grant_ca;
    ovfl_d  = ovfl_q;
    undfl_d = undfl_q;
    if (io_cpx_err_clr) begin
      ovfl_d  = 1'b0;
      undfl_d = 1'b0;
    end
    // New error events win over a same-cycle clear.
    if (|(io_cpx_req_cq & full)) begin
      ovfl_d = 1'b1;
    end
    if (|(cpx_io_grant_ca & empty)) begin
      undfl_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int d = 0; d < NDEST; d++) begin
        cnt_q[d] <= '0;
      end
      req_q   <= '0;
      grant_q <= '0;
      ovfl_q  <= 1'b0;
      undfl_q <= 1'b0;
    end else begin
      for (int d = 0; d < NDEST; d++) begin
        cnt_q[d] <= cnt_d[d];
      end
      req_q   <= req_d;
      grant_q <= grant_d;
      ovfl_q  <= ovfl_d;
      undfl_q <= undfl_d;
    end
  end

  generate
    if (REQ_ACTIVE_LOW) begin : g_req_low
      assign io_cpx_req_bufio_cq_l = ~req_q;
    end else begin : g_req_high
      assign io_cpx_req_bufio_cq_l = req_q;
    end
  endgenerate

  assign cpx_io_grant_bufio_ca = grant_q;
  assign io_cpx_stall_cq       = full;
  assign io_cpx_busy           = |(~empty);
  assign io_cpx_ovfl_err       = ovfl_q;
  assign io_cpx_undfl_err      = undfl_q;

endmodule

// File: tb/tb_cpx_io_req_credit_buf.sv
// Directed table-driven bench for cpx_io_req_credit_buf: default 8-dest instance plus
// a 4-dest, DEPTH=3, active-high-request instance.
module tb_cpx_io_req_credit_buf;

  logic       rclk;
  logic       arst_l;
  logic [7:0] req8, gnt8;
  logic       clr8;
  logic [7:0] req_l8, gnt_o8, stall8;
  logic       busy8, ovfl8, undfl8;
  logic [3:0] req4, gnt4;
  logic       clr4;
  logic [3:0] req_o4, gnt_o4, stall4;
  logic       busy4, ovfl4, undfl4;

  int n_cmp = 0;
  int n_err = 0;

  cpx_io_req_credit_buf u_dut8 (
    .rclk                  (rclk),
    .arst_l                (arst_l),
    .io_cpx_req_cq         (req8),
    .cpx_io_grant_ca       (gnt8),
    .io_cpx_err_clr        (clr8),
    .io_cpx_req_bufio_cq_l (req_l8),
    .cpx_io_grant_bufio_ca (gnt_o8),
    .io_cpx_stall_cq       (stall8),
    .io_cpx_busy           (busy8),
    .io_cpx_ovfl_err       (ovfl8),
    .io_cpx_undfl_err      (undfl8)
  );

  cpx_io_req_credit_buf #(
    .NDEST(4), .DEPTH(3), .CNTW(2), .REQ_ACTIVE_LOW(1'b0)
  ) u_dut4 (
    .rclk                  (rclk),
    .arst_l                (arst_l),
    .io_cpx_req_cq         (req4),
    .cpx_io_grant_ca       (gnt4),
    .io_cpx_err_clr        (clr4),
    .io_cpx_req_bufio_cq_l (req_o4),
    .cpx_io_grant_bufio_ca (gnt_o4),
    .io_cpx_stall_cq       (stall4),
    .io_cpx_busy           (busy4),
    .io_cpx_ovfl_err       (ovfl4),
    .io_cpx_undfl_err      (undfl4)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] req;
    logic [7:0] gnt;
    logic       clr;
    logic [7:0] e_req_l;
    logic [7:0] e_gnt;
    logic [7:0] e_stall;
    logic       e_busy;
    logic       e_ovfl;
    logic       e_undfl;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] e_req_l, input logic [7:0] e_gnt,
                      input logic [7:0] e_stall, input logic e_busy, input logic e_ovfl,
                      input logic e_undfl);
    chk({tag, ".req_l"}, req_l8, e_req_l);
    chk({tag, ".gnt"},   gnt_o8, e_gnt);
    chk({tag, ".stall"}, stall8, e_stall);
    chk({tag, ".busy"},  {7'd0, busy8},  {7'd0, e_busy});
    chk({tag, ".ovfl"},  {7'd0, ovfl8},  {7'd0, e_ovfl});
    chk({tag, ".undfl"}, {7'd0, undfl8}, {7'd0, e_undfl});
  endtask

  task automatic chk4(input string tag, input logic [3:0] e_req, input logic [3:0] e_stall,
                      input logic e_busy, input logic e_ovfl);
    chk({tag, ".req4"},   {4'd0, req_o4}, {4'd0, e_req});
    chk({tag, ".stall4"}, {4'd0, stall4}, {4'd0, e_stall});
    chk({tag, ".busy4"},  {7'd0, busy4},  {7'd0, e_busy});
    chk({tag, ".ovfl4"},  {7'd0, ovfl4},  {7'd0, e_ovfl});
  endtask

  // Drive on the falling edge, sample just after the following rising edge.
  task automatic step8(input logic [7:0] r, input logic [7:0] g, input logic c);
    @(negedge rclk);
    req8 = r; gnt8 = g; clr8 = c;
    @(posedge rclk);
    #1;
  endtask

  task automatic step4(input logic [3:0] r, input logic [3:0] g);
    @(negedge rclk);
    req4 = r; gnt4 = g;
    req8 = '0; gnt8 = '0; clr8 = 1'b0;
    @(posedge rclk);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    // Each row: inputs for one cycle, outputs expected right after that edge.
    vecs[0]  = '{8'h01, 8'h00, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h01, 8'h00, 1'b0, 8'hFE, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h01, 8'h01, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{8'h20, 8'h00, 1'b0, 8'hDF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8'h20, 8'h20, 1'b0, 8'hDF, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 8'h80, 1'b0, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 8'h80, 1'b1, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'h20, 1'b0, 8'hFF, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h08, 8'h00, 1'b0, 8'hF7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'h08, 8'h02, 1'b0, 8'hF7, 8'h02, 8'h08, 1'b1, 1'b0, 1'b1};

    arst_l = 1'b0;
    req8 = '0; gnt8 = '0; clr8 = 1'b0;
    req4 = '0; gnt4 = '0; clr4 = 1'b0;
    #1;
    chk8("rst0", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk4("rst0", 4'h0, 4'h0, 1'b0, 1'b0);

    @(negedge rclk);
    arst_l = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step8(vecs[i].req, vecs[i].gnt, vecs[i].clr);
      chk8($sformatf("vec%0d", i), vecs[i].e_req_l, vecs[i].e_gnt, vecs[i].e_stall,
           vecs[i].e_busy, vecs[i].e_ovfl, vecs[i].e_undfl);
    end

    // Mid-run reset with cnt[3]=2, grant and undfl in flight: outputs clear at once.
    #2;
    arst_l = 1'b0;
    #1;
    chk8("rst_mid", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge rclk);
    req8 = '0; gnt8 = '0;
    arst_l = 1'b1;
    step8(8'h00, 8'h00, 1'b0);
    chk8("post_rst_idle", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // Count restarted from zero: first request accepted, stall only after the second.
    step8(8'h08, 8'h00, 1'b0);
    chk8("post_rst_r1", 8'hF7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step8(8'h08, 8'h00, 1'b0);
    chk8("post_rst_r2", 8'hF7, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0);
    // Source ignores stall: dropped and flagged, no grant so count stays at DEPTH.
    step8(8'h08, 8'h00, 1'b0);
    chk8("post_rst_r3", 8'hFF, 8'h00, 8'h08, 1'b1, 1'b1, 1'b0);

    // DEPTH=3 active-high instance on destination 2.
    step4(4'h4, 4'h0);
    chk4("p_r1", 4'h4, 4'h0, 1'b1, 1'b0);
    step4(4'h4, 4'h0);
    chk4("p_r2", 4'h4, 4'h0, 1'b1, 1'b0);
    step4(4'h4, 4'h0);
    chk4("p_r3", 4'h4, 4'h4, 1'b1, 1'b0);
    step4(4'h4, 4'h0);
    chk4("p_r4", 4'h0, 4'h4, 1'b1, 1'b1);
    step4(4'h0, 4'h4);
    chk4("p_g1", 4'h0, 4'h0, 1'b1, 1'b1);
    chk("p_g1.gnt4", {4'd0, gnt_o4}, 8'h04);
    chk("p_g1.undfl4", {7'd0, undfl4}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpx_io_req_credit_buf.md
# cpx_io_req_credit_buf

Parametrised, registered successor to the IO-side CPX request/grant buffer. Sits between the IO bridge CPX source and the CPX arbiter/crossbar. Repeats per-destination requests and grants through one flop stage with selectable request polarity. Tracks outstanding requests per destination against the CPX queue depth, back-pressures the source with a per-destination stall, and drops and flags requests that would overflow the destination queue.

## Interface
Parameters:
- NDEST, 8, number of CPX destinations (one request/grant bit each)
- DEPTH, 2, maximum outstanding (requested, not yet granted) packets per destination; range 1..(2^CNTW)-1
- CNTW, 2, width of each per-destination counter
- REQ_ACTIVE_LOW, 1, 1: request output is active-low; 0: active-high

Ports:
- rclk  in  1  clock; all state on rising edge
- arst_l  in  1  reset, asynchronous assert, active-low
- io_cpx_req_cq  in  NDEST  source request, one packet per asserted bit per cycle, active-high
- cpx_io_grant_ca  in  NDEST  arbiter grant, one packet retired per asserted bit per cycle
- io_cpx_err_clr  in  1  synchronous clear of sticky error flags
- io_cpx_req_bufio_cq_l  out  NDEST  registered forwarded request, polarity per REQ_ACTIVE_LOW
- cpx_io_grant_bufio_ca  out  NDEST  registered grant to source
- io_cpx_stall_cq  out  NDEST  destination d has DEPTH packets outstanding
- io_cpx_busy  out  1  any destination has a nonzero count
- io_cpx_ovfl_err  out  1  sticky: request arrived for a full destination
- io_cpx_undfl_err  out  1  sticky: grant arrived for a destination with count 0

## Operation
- Per destination d, counter cnt[d] (CNTW bits), range 0..DEPTH.
- full[d] = (cnt[d] == DEPTH); empty[d] = (cnt[d] == 0), both from the registered counter.
- acc[d] = req_in[d] & ~full[d]; ret[d] = grant_in[d] & ~empty[d].
- Counter update: acc & ~ret -> +1; ret & ~acc -> -1; both or neither -> hold. The counter never wraps.
- A request at full is dropped even if a grant arrives in the same cycle. It is not forwarded, the count is unchanged, and ovfl_err is set.
- A grant at empty is still forwarded to the source. The count is unchanged and undfl_err is set.
- Forwarded request register: req_q[d] <= acc[d]. Output = REQ_ACTIVE_LOW ? ~req_q : req_q.
- Grant register: grant_q[d] <= grant_in[d], unconditionally forwarded.
- stall[d] = full[d]. busy = OR over all d of ~empty[d].
- Sticky errors: set has priority over io_cpx_err_clr when both occur in the same cycle. Otherwise err_clr clears the flag on the next edge.
- Destinations are fully independent; there is no cross-destination arbitration.

## Timing
- Reset (arst_l low, asynchronous): cnt = 0; req_q = 0, so io_cpx_req_bufio_cq_l = all ones when REQ_ACTIVE_LOW=1 and all zeros otherwise; cpx_io_grant_bufio_ca = 0; stall = 0; busy = 0; both errors = 0.
- Reset release is synchronous to rclk; the first accepted request is taken on the first rising edge with arst_l high.
- Reset mid-operation discards all outstanding counts and any in-flight req_q/grant_q.
- Request latency: req_in in cycle N -> forwarded request out in cycle N+1.
- Grant latency: grant_in in cycle N -> grant out in cycle N+1.
- Counter/stall/busy: an event in cycle N is visible in cycle N+1.
- Stall is a registered view. A source that ignores stall for one cycle after a count reaches DEPTH sees its request dropped and flagged; the source must sample stall before issuing.
- Error flags assert in cycle N+1 for an offending event in cycle N.

## Test plan
- Reset values: assert arst_l mid-run with cnt[3]=2 -> all outputs at reset values immediately (req_l = 8'hFF with defaults); after release, cnt all 0.
- Fill and stall: req bit 0 in cycles 1 and 2 -> req_l[0] low in cycles 2 and 3; stall[0]=1 from cycle 3; busy=1.
- Overflow: with cnt[0]=2, req bit 0 plus grant bit 0 in the same cycle -> request not forwarded; count goes 2->1 next cycle; ovfl_err=1; grant forwarded.
- Simultaneous accept and return: cnt[5]=1, req and grant on bit 5 -> req_l[5] low; grant out[5] high next cycle; cnt stays 1.
- Underflow and clear: grant on bit 7 with cnt[7]=0 -> grant forwarded, undfl_err=1. Then err_clr alone clears it next cycle. Err_clr in the same cycle as a new underflow keeps the flag at 1.
- Parameter sweep: NDEST=4, DEPTH=3, CNTW=2, REQ_ACTIVE_LOW=0 -> three accepts stall the destination, the fourth is dropped, and the request output is active-high with reset value 4'h0.
